// File: rtl/mcdf_cmd_pkg.sv
// Shared definitions for the MCDF control-register command initiator.
// Holds the bus command encodings, default address/data widths, the
// initiator FSM state type and the packed request record layout.
package mcdf_cmd_pkg;

    localparam int CMD_ADDR_W = 8;
    localparam int CMD_DATA_W = 32;

    // Encodings seen by the register responder on its cmd input.
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    // Request record at the default widths. The FIFO stores the same
    // {write, addr, wdata} ordering flattened to a vector.
    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/cmd_req_fifo.sv
// Synchronous request FIFO, no fall-through: an entry pushed at an edge
// becomes visible at the head only after that edge.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (flushes pointers)
//   push, push_data write side; push is ignored while full
//   pop             read side; pop is ignored while empty
//   head            current head entry (valid when !empty)
//   full, empty     decoded from registered pointers only
// DEPTH must be a power of two and at least 2.
module cmd_req_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra MSB so full and empty can be told apart
    // when the index bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/ctrl_cmd_master.sv
// Command-bus initiator for the MCDF control-register block.
// Host requests are buffered in cmd_req_fifo and issued one at a time as a
// single-cycle WRITE or READ on the cmd bus. Read data returned by the
// responder is captured and offered on a response channel.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid, once raised, holds its payload stable until that edge;
// ready may be driven freely and does not depend on valid.
//
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   req_valid_i/req_ready_o         request handshake (ready = FIFO not full)
//   req_write_i, req_addr_i,
//   req_wdata_i                     request payload (wdata unused for reads)
//   rsp_valid_o/rsp_ready_i         read response handshake
//   rsp_data_o                      captured read data
//   cmd_o, cmd_addr_o, cmd_wdata_o  command bus to the register responder
//   cmd_rdata_i                     responder's registered read data
//   busy_o                          FSM active or requests still queued
module ctrl_cmd_master
    import mcdf_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = CMD_ADDR_W,
    parameter int DATA_WIDTH = CMD_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [1:0]            cmd_o,
    output logic [ADDR_WIDTH-1:0] cmd_addr_o,
    output logic [DATA_WIDTH-1:0] cmd_wdata_o,
    input  logic [DATA_WIDTH-1:0] cmd_rdata_i,
    output logic                  busy_o
);

    localparam int REQ_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [REQ_W-1:0]      fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    cmd_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (req_valid_i && !fifo_full),
        .push_data ({req_write_i, req_addr_i, req_wdata_i}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_write, head_addr, head_wdata} = fifo_head;

    // FSM state and registered outputs
    state_e                state, state_n;
    cmd_e                  cmd, cmd_n;
    logic [ADDR_WIDTH-1:0] cmd_addr, cmd_addr_n;
    logic [DATA_WIDTH-1:0] cmd_wdata, cmd_wdata_n;
    logic                  rsp_valid, rsp_valid_n;
    logic [DATA_WIDTH-1:0] rsp_data, rsp_data_n;
    logic                  load;

    always_comb begin
        state_n     = state;
        cmd_n       = CMD_IDLE;
        cmd_addr_n  = cmd_addr;
        cmd_wdata_n = cmd_wdata;
        rsp_valid_n = rsp_valid;
        rsp_data_n  = rsp_data;
        load        = 1'b0;
        fifo_pop    = 1'b0;

        case (state)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_ISSUE: begin
                // cmd still holds the command being driven this cycle.
                if (cmd == CMD_READ) begin
                    state_n = ST_WAIT;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Responder registered its read data at the end of ISSUE.
                rsp_data_n  = cmd_rdata_i;
                rsp_valid_n = 1'b1;
                state_n     = ST_RESP;
            end
            ST_RESP: begin
                // Nothing is popped while a response is pending.
                if (rsp_ready_i) begin
                    rsp_valid_n = 1'b0;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            fifo_pop    = 1'b1;
            state_n     = ST_ISSUE;
            cmd_n       = head_write ? CMD_WRITE : CMD_READ;
            cmd_addr_n  = head_addr;
            cmd_wdata_n = head_write ? head_wdata : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cmd       <= CMD_IDLE;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cmd       <= cmd_n;
            cmd_addr  <= cmd_addr_n;
            cmd_wdata <= cmd_wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
        end
    end

    assign cmd_o       = cmd;
    assign cmd_addr_o  = cmd_addr;
    assign cmd_wdata_o = cmd_wdata;
    assign rsp_valid_o = rsp_valid;
    assign rsp_data_o  = rsp_data;
    assign req_ready_o = !fifo_full;
    assign busy_o      = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_ctrl_cmd_master.sv
// Bench for ctrl_cmd_master: responder model, bus and response scoreboards,
// a table of mixed requests plus directed multi-cycle sequences.
module tb_ctrl_cmd_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [7:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_data_o;
    logic [1:0]  cmd_o;
    logic [7:0]  cmd_addr_o;
    logic [31:0] cmd_wdata_o;
    logic [31:0] cmd_rdata_i;
    logic        busy_o;

    ctrl_cmd_master #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .cmd_o       (cmd_o),
        .cmd_addr_o  (cmd_addr_o),
        .cmd_wdata_o (cmd_wdata_o),
        .cmd_rdata_i (cmd_rdata_i),
        .busy_o      (busy_o)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters and check ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- responder model ----------------
    logic [31:0] resp_mem [256];

    always @(posedge clk) begin
        if (rst_i) begin
            for (int i = 0; i < 256; i++) resp_mem[i] <= (i == 16) ? 32'h20 : 32'h0;
            cmd_rdata_i <= 32'h0;
        end else if (cmd_o == 2'b10) begin
            resp_mem[cmd_addr_o] <= cmd_wdata_o;
        end else if (cmd_o == 2'b01) begin
            cmd_rdata_i <= resp_mem[cmd_addr_o];
        end
    end

    // ---------------- scoreboards ----------------
    logic [41:0] exp_cmd_q [$];
    logic [31:0] exp_rsp_q [$];
    int          cmd_cyc_q [$];
    int          last_hs_cyc = 0;
    logic [41:0] bus_e;
    logic [31:0] rsp_e;

    always @(negedge clk) begin
        if (!rst_i && cmd_o != 2'b00) begin
            cmd_cyc_q.push_back(cyc);
            if (exp_cmd_q.size() == 0) begin
                check("bus_unexpected", 64'({cmd_o, cmd_addr_o, cmd_wdata_o}), 64'd0);
            end else begin
                bus_e = exp_cmd_q.pop_front();
                check("bus_cmd", 64'({cmd_o, cmd_addr_o, cmd_wdata_o}), 64'(bus_e));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            last_hs_cyc = cyc + 1;
            if (exp_rsp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_data_o), 64'hdead_0000_0000);
            end else begin
                rsp_e = exp_rsp_q.pop_front();
                check("rsp_data", 64'(rsp_data_o), 64'(rsp_e));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic push_req(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, output int acc);
        int budget;
        budget      = 100;
        acc         = -1;
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        @(negedge clk);
        while (!req_ready_o && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (!req_ready_o) begin
            check("push_accept", 64'(req_ready_o), 64'd1);
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            req_valid_i = 1'b0;
            acc = cyc;
            exp_cmd_q.push_back({(wr ? 2'b10 : 2'b01), addr, (wr ? wdata : 32'h0)});
            if (!wr) exp_rsp_q.push_back(exp_rd);
        end
    endtask

    // Waits for rsp_valid_o; returns the edge index it rose on, realigned to posedge+1.
    task automatic wait_rsp_valid(input string name, output int seen);
        int budget;
        budget = 100;
        @(negedge clk);
        while (!rsp_valid_o && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        seen = cyc;
        check(name, 64'(rsp_valid_o), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 200;
        @(negedge clk);
        while ((busy_o || rsp_valid_o) && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        check(name, 64'(busy_o), 64'd0);
        check({name, "_cmdq"}, 64'(exp_cmd_q.size()), 64'd0);
        check({name, "_rspq"}, 64'(exp_rsp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    // ---------------- test ----------------
    initial begin
        int acc, acc_w, acc_r, seen;
        logic [7:0] full_addr [4];

        vecs[0] = '{1'b1, 8'h20, 32'h0000_00A1, 32'h0};
        vecs[1] = '{1'b1, 8'h24, 32'h0000_00B2, 32'h0};
        vecs[2] = '{1'b0, 8'h20, 32'h0,         32'h0000_00A1};
        vecs[3] = '{1'b1, 8'h28, 32'h0000_00C3, 32'h0};
        vecs[4] = '{1'b0, 8'h24, 32'h0,         32'h0000_00B2};
        vecs[5] = '{1'b0, 8'h28, 32'h0,         32'h0000_00C3};
        vecs[6] = '{1'b1, 8'h20, 32'h0000_00D4, 32'h0};
        vecs[7] = '{1'b0, 8'h20, 32'h0,         32'h0000_00D4};
        vecs[8] = '{1'b0, 8'h08, 32'h0,         32'h0000_0033};
        vecs[9] = '{1'b0, 8'h14, 32'h0,         32'h0000_0055};

        full_addr[0] = 8'h00;
        full_addr[1] = 8'h04;
        full_addr[2] = 8'h08;
        full_addr[3] = 8'h00;

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 8'h0;
        req_wdata_i = 32'h0;
        rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_cmd",       64'(cmd_o),       64'd0);
        check("rst_cmd_addr",  64'(cmd_addr_o),  64'd0);
        check("rst_cmd_wdata", 64'(cmd_wdata_o), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_data",  64'(rsp_data_o),  64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_busy",      64'(busy_o),      64'd0);
        @(posedge clk);
        #1;

        // Single write then read with latency checks
        cmd_cyc_q.delete();
        push_req(1'b1, 8'h00, 32'h0000_003D, 32'h0, acc_w);
        push_req(1'b0, 8'h00, 32'h0,         32'h0000_003D, acc_r);
        wait_rsp_valid("wr_rd_valid", seen);
        check("wr_issue_cyc", 64'(cmd_cyc_q[0]), 64'(acc_w + 1));
        check("rd_issue_cyc", 64'(cmd_cyc_q[1]), 64'(acc_r + 1));
        check("rd_latency",   64'(seen),         64'(acc_r + 3));
        wait_idle("wr_rd_idle");

        // Back-to-back writes
        cmd_cyc_q.delete();
        push_req(1'b1, 8'h00, 32'h0000_0011, 32'h0, acc_w);
        push_req(1'b1, 8'h04, 32'h0000_0022, 32'h0, acc);
        push_req(1'b1, 8'h08, 32'h0000_0033, 32'h0, acc);
        wait_idle("b2b_idle");
        check("b2b_count", 64'(cmd_cyc_q.size()), 64'd3);
        if (cmd_cyc_q.size() == 3) begin
            check("b2b_first", 64'(cmd_cyc_q[0]), 64'(acc_w + 1));
            check("b2b_second", 64'(cmd_cyc_q[1]), 64'(acc_w + 2));
            check("b2b_third", 64'(cmd_cyc_q[2]), 64'(acc_w + 3));
        end

        // FIFO full while a read response is held
        rsp_ready_i = 1'b0;
        push_req(1'b0, 8'h08, 32'h0, 32'h0000_0033, acc);
        wait_rsp_valid("full_pend_valid", seen);
        for (int i = 0; i < 4; i++) begin
            push_req(1'b0, full_addr[i], 32'h0, (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : 32'h11, acc);
        end
        @(negedge clk);
        check("full_ready", 64'(req_ready_o), 64'd0);
        check("full_busy",  64'(busy_o),      64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = 8'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_hold", 64'(req_ready_o), 64'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready_i = 1'b1;
        push_req(1'b0, 8'h08, 32'h0, 32'h0000_0033, acc);
        check("full_accept_cyc", 64'(acc), 64'(last_hs_cyc + 1));
        wait_idle("full_idle");

        // Response backpressure with a write queued behind the read
        cmd_cyc_q.delete();
        rsp_ready_i = 1'b0;
        push_req(1'b0, 8'h10, 32'h0, 32'h0000_0020, acc);
        push_req(1'b1, 8'h14, 32'h0000_0055, 32'h0, acc);
        wait_rsp_valid("bp_valid", seen);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data",  64'(rsp_data_o),  64'h20);
            check("bp_valid", 64'(rsp_valid_o), 64'd1);
            check("bp_cmd",   64'(cmd_o),       64'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready_i = 1'b1;
        wait_idle("bp_idle");
        check("bp_cmd_count", 64'(cmd_cyc_q.size()), 64'd2);
        if (cmd_cyc_q.size() == 2) begin
            check("bp_next_issue", 64'(cmd_cyc_q[1]), 64'(last_hs_cyc));
        end

        // Ordering across pointer wrap from the vector table
        for (int i = 0; i < 10; i++) begin
            push_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, acc);
        end
        wait_idle("order_idle");

        // Reset in WAIT discards the pending read
        push_req(1'b0, 8'h14, 32'h0, 32'h0000_0055, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("wait_busy", 64'(busy_o), 64'd1);
        check("wait_cmd",  64'(cmd_o),  64'd0);
        rst_i = 1'b1;
        #1;
        check("mid_rst_cmd",       64'(cmd_o),       64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready_o), 64'd1);
        check("mid_rst_busy",      64'(busy_o),      64'd0);
        exp_rsp_q.delete();
        exp_cmd_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_rsp_data", 64'(rsp_data_o), 64'd0);
        push_req(1'b0, 8'h10, 32'h0, 32'h0000_0020, acc);
        wait_rsp_valid("post_rst_valid", seen);
        check("post_rst_latency", 64'(seen), 64'(acc + 3));
        wait_idle("post_rst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
